// File: rtl/clock_domain_reset_sequencer.sv
// Power-up reset sequencer for the media computer clock domains.
// Releases SDRAM, system, VGA, MTL and audio resets in order once the PLL lock is stable.
//
// state      | meaning
// HOLD       | just out of reset, everything held
// WAIT_LOCK  | filtering pll_locked before the first release
// WAIT_SDRAM | SDRAM released, waiting for its power-up delay
// REL_SYS    | system released, staggering to VGA
// REL_VGA    | VGA released, staggering to MTL
// REL_MTL    | MTL released, staggering to audio
// REL_AUDIO  | reserved, never entered
// RUN        | all domains released
// SW_HOLD    | software-requested hold before relocking
module clock_domain_reset_sequencer #(
    parameter int LOCK_FILTER = 1024,
    parameter int SDRAM_WAIT  = 10000,
    parameter int STAGGER     = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk_50_in_clk,
    input  logic       reset_in_reset,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       rst_sdram_out,
    output logic       rst_sys_out,
    output logic       rst_vga_out,
    output logic       rst_mtl_out,
    output logic       rst_audio_out,
    output logic       ready,
    output logic [3:0] seq_state,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [3:0] {
        HOLD       = 4'd0,
        WAIT_LOCK  = 4'd1,
        WAIT_SDRAM = 4'd2,
        REL_SYS    = 4'd3,
        REL_VGA    = 4'd4,
        REL_MTL    = 4'd5,
        REL_AUDIO  = 4'd6,
        RUN        = 4'd7,
        SW_HOLD    = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] SDRAM_TC = CNT_W'(SDRAM_WAIT - 1);
    localparam logic [CNT_W-1:0] STAG_TC  = CNT_W'(STAGGER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rst_q, rst_d;
    logic             ready_q, ready_d;
    logic [7:0]       llc_q, llc_d;
    logic             lock_loss;
    logic             sw_hit;

    always_comb begin
        state_d   = state_q;
        llc_d     = llc_q;
        lock_loss = !pll_locked && (state_q != HOLD) && (state_q != WAIT_LOCK)
                    && (state_q != SW_HOLD);
        sw_hit    = sw_reset_req && (state_q != HOLD) && (state_q != SW_HOLD);

        if (lock_loss) begin
            state_d = WAIT_LOCK;
            if (llc_q != 8'hFF) begin
                llc_d = llc_q + 8'd1;
            end
        end else if (sw_hit) begin
            state_d = SW_HOLD;
        end else begin
            case (state_q)
                HOLD:       state_d = WAIT_LOCK;
                WAIT_LOCK:  if (pll_locked && cnt_q == LOCK_TC) state_d = WAIT_SDRAM;
                WAIT_SDRAM: if (cnt_q == SDRAM_TC) state_d = REL_SYS;
                REL_SYS:    if (cnt_q == STAG_TC) state_d = REL_VGA;
                REL_VGA:    if (cnt_q == STAG_TC) state_d = REL_MTL;
                REL_MTL:    if (cnt_q == STAG_TC) state_d = RUN;
                RUN:        state_d = RUN;
                SW_HOLD:    if (cnt_q == STAG_TC) state_d = WAIT_LOCK;
                default:    state_d = HOLD;
            endcase
        end

        // Lock filter restarts whenever the lock drops while still filtering.
        if ((state_d != state_q) || (state_q == WAIT_LOCK && !pll_locked)) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Reset outputs decode the next state so each one is a clean flop output.
        case (state_d)
            WAIT_SDRAM: rst_d = 5'b01111;
            REL_SYS:    rst_d = 5'b00111;
            REL_VGA:    rst_d = 5'b00011;
            REL_MTL:    rst_d = 5'b00001;
            REL_AUDIO:  rst_d = 5'b00001;
            RUN:        rst_d = 5'b00000;
            default:    rst_d = 5'b11111;
        endcase
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk_50_in_clk or posedge reset_in_reset) begin
        if (reset_in_reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_q   <= 5'b11111;
            ready_q <= 1'b0;
            llc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            llc_q   <= llc_d;
        end
    end

    assign rst_sdram_out   = rst_q[4];
    assign rst_sys_out     = rst_q[3];
    assign rst_vga_out     = rst_q[2];
    assign rst_mtl_out     = rst_q[1];
    assign rst_audio_out   = rst_q[0];
    assign ready           = ready_q;
    assign seq_state       = state_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_clock_domain_reset_sequencer.sv
// Directed bench for clock_domain_reset_sequencer with small timing parameters.
module tb_clock_domain_reset_sequencer;

    logic       clk;
    logic       reset_in_reset;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       rst_sdram_out, rst_sys_out, rst_vga_out, rst_mtl_out, rst_audio_out;
    logic       ready;
    logic [3:0] seq_state;
    logic [7:0] lock_loss_count;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        int         edge_idx;
        logic [4:0] rst;
        logic       rdy;
        logic [3:0] st;
    } vec_t;

    vec_t nom [12];

    clock_domain_reset_sequencer #(
        .LOCK_FILTER(8),
        .SDRAM_WAIT (20),
        .STAGGER    (4),
        .CNT_W      (16)
    ) dut (
        .clk_50_in_clk  (clk),
        .reset_in_reset (reset_in_reset),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .rst_sdram_out  (rst_sdram_out),
        .rst_sys_out    (rst_sys_out),
        .rst_vga_out    (rst_vga_out),
        .rst_mtl_out    (rst_mtl_out),
        .rst_audio_out  (rst_audio_out),
        .ready          (ready),
        .seq_state      (seq_state),
        .lock_loss_count(lock_loss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #2;
        edge_n++;
    endtask

    task automatic advance_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic check(input string name, input logic [4:0] er, input logic erdy,
                         input logic [3:0] est, input logic [7:0] ellc);
        logic [17:0] act;
        logic [17:0] exp;
        act = {rst_sdram_out, rst_sys_out, rst_vga_out, rst_mtl_out, rst_audio_out,
               ready, seq_state, lock_loss_count};
        exp = {er, erdy, est, ellc};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got rst=%b rdy=%b st=%0d llc=%0d, want rst=%b rdy=%b st=%0d llc=%0d",
                     name, edge_n, act[17:13], act[12], act[11:8], act[7:0],
                     er, erdy, est, ellc);
        end
    endtask

    task automatic do_reset();
        reset_in_reset = 1'b1;
        sw_reset_req   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_in_reset = 1'b0;
        edge_n = 0;
    endtask

    // Edges are relative to the edge before WAIT_LOCK entry (entry itself is offset+1).
    task automatic run_table(input string tag, input int offset, input logic [7:0] llc);
        for (int i = 0; i < 12; i++) begin
            advance_to(nom[i].edge_idx + offset);
            check($sformatf("%s_v%0d", tag, i), nom[i].rst, nom[i].rdy, nom[i].st, llc);
        end
    endtask

    initial begin
        nom[0]  = '{1,  5'b11111, 1'b0, 4'd1};
        nom[1]  = '{8,  5'b11111, 1'b0, 4'd1};
        nom[2]  = '{9,  5'b01111, 1'b0, 4'd2};
        nom[3]  = '{28, 5'b01111, 1'b0, 4'd2};
        nom[4]  = '{29, 5'b00111, 1'b0, 4'd3};
        nom[5]  = '{32, 5'b00111, 1'b0, 4'd3};
        nom[6]  = '{33, 5'b00011, 1'b0, 4'd4};
        nom[7]  = '{36, 5'b00011, 1'b0, 4'd4};
        nom[8]  = '{37, 5'b00001, 1'b0, 4'd5};
        nom[9]  = '{40, 5'b00001, 1'b0, 4'd5};
        nom[10] = '{41, 5'b00000, 1'b1, 4'd7};
        nom[11] = '{45, 5'b00000, 1'b1, 4'd7};

        pll_locked     = 1'b1;
        sw_reset_req   = 1'b0;
        reset_in_reset = 1'b1;

        // nominal sequence
        do_reset();
        check("reset_vals", 5'b11111, 1'b0, 4'd0, 8'd0);
        run_table("nominal", 0, 8'd0);

        // lock loss in RUN, then replay
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        run_table("lockloss", 45, 8'd1);

        // lock filter restart
        do_reset();
        advance_to(6);
        pll_locked = 1'b0;
        step();
        check("filt_drop", 5'b11111, 1'b0, 4'd1, 8'd0);
        pll_locked = 1'b1;
        advance_to(14);
        check("filt_hold", 5'b11111, 1'b0, 4'd1, 8'd0);
        advance_to(15);
        check("filt_rel", 5'b01111, 1'b0, 4'd2, 8'd0);

        // software reset mid-sequence, second request ignored in SW_HOLD
        do_reset();
        advance_to(34);
        check("sw_pre", 5'b00011, 1'b0, 4'd4, 8'd0);
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("sw_enter", 5'b11111, 1'b0, 4'd8, 8'd0);
        step();
        check("sw_hold1", 5'b11111, 1'b0, 4'd8, 8'd0);
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("sw_ignore", 5'b11111, 1'b0, 4'd8, 8'd0);
        step();
        check("sw_hold3", 5'b11111, 1'b0, 4'd8, 8'd0);
        step();
        check("sw_exit", 5'b11111, 1'b0, 4'd1, 8'd0);
        run_table("after_sw", 38, 8'd0);

        // simultaneous lock loss and sw request in RUN
        sw_reset_req = 1'b1;
        pll_locked   = 1'b0;
        step();
        sw_reset_req = 1'b0;
        pll_locked   = 1'b1;
        check("simul", 5'b11111, 1'b0, 4'd1, 8'd1);

        // 300 lock-loss events from WAIT_SDRAM
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            repeat (8) step();
            pll_locked = 1'b0;
            step();
            if (i == 99) check("llc_101", 5'b11111, 1'b0, 4'd1, 8'd101);
        end
        check("llc_sat", 5'b11111, 1'b0, 4'd1, 8'd255);
        pll_locked = 1'b1;
        repeat (40) step();
        check("run_sat", 5'b00000, 1'b1, 4'd7, 8'd255);

        // asynchronous reset between edges
        #1;
        reset_in_reset = 1'b1;
        #1;
        check("async_rst", 5'b11111, 1'b0, 4'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
